// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared decode-stage pipeline definitions: register address width, sequencer
// states, the NOP word used by flush/bubble consumers, and the control bundle.
package hazard_stall_ctrl_pkg;

  localparam int REG_AW = 3;

  // Encoding loaded into IF/ID on flush and into ID/EX on bubble.
  localparam logic [15:0] NOP_INSN = 16'h0000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    INT_SEQ    = 2'd2
  } state_e;

  typedef struct packed {
    logic stall_fetch;
    logic stall_decode;
    logic flush_decode;
    logic bubble_exe;
    logic int_ack;
    logic int_active;
  } ctrl_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_cmp.sv
// Combinational load-use hazard compare: any used decode operand matching the
// destination of a load in EXE that writes back.
module hazard_cmp #(
  parameter int AW      = hazard_stall_ctrl_pkg::REG_AW,
  parameter int NUM_OPS = 2
) (
  input  logic [NUM_OPS-1:0][AW-1:0] op_reg,
  input  logic [NUM_OPS-1:0]         op_used,
  input  logic [AW-1:0]              ex_dest,
  input  logic                       ex_wb,
  input  logic                       ex_mem_read,
  output logic                       hazard
);

  logic [NUM_OPS-1:0] match;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    assign match[i] = op_used[i] && (op_reg[i] == ex_dest);
  end

  assign hazard = ex_wb && ex_mem_read && (|match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage sequencer: load-use stalls, taken-branch flush, multi-cycle
// interrupt entry, and a saturating stall-cycle counter for debug.
module hazard_stall_ctrl #(
  parameter int REG_AW     = hazard_stall_ctrl_pkg::REG_AW,
  parameter int LOAD_LAT   = 1,
  parameter int INT_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] dec_src,
  input  logic              dec_src_used,
  input  logic [REG_AW-1:0] dec_dst,
  input  logic              dec_dst_used,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_wb,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              int_req,
  output logic              stall_fetch,
  output logic              stall_decode,
  output logic              flush_decode,
  output logic              bubble_exe,
  output logic              int_ack,
  output logic              int_active,
  output logic [CNT_W-1:0]  stall_count
);
  import hazard_stall_ctrl_pkg::*;

  localparam int CNT_MAX = max2(LOAD_LAT, INT_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             hazard;
  ctrl_t            ctrl, ctrl_out;

  hazard_cmp #(.AW(REG_AW), .NUM_OPS(2)) u_hazard_cmp (
    .op_reg      ({dec_dst, dec_src}),
    .op_used     ({dec_dst_used, dec_src_used}),
    .ex_dest     (ex_dest),
    .ex_wb       (ex_wb),
    .ex_mem_read (ex_mem_read),
    .hazard      (hazard)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = '0;
    case (state_q)
      IDLE: begin
        if (ex_branch_taken) begin
          ctrl.flush_decode = 1'b1;
          ctrl.bubble_exe   = 1'b1;
        end else if (hazard) begin
          ctrl.stall_fetch  = 1'b1;
          ctrl.stall_decode = 1'b1;
          ctrl.bubble_exe   = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LOAD_STALL;
            cnt_d   = CW'(LOAD_LAT - 1);
          end
        end else if (int_req) begin
          // IF/ID is flushed, so its stall stays low: flush wins.
          ctrl.stall_fetch  = 1'b1;
          ctrl.flush_decode = 1'b1;
          ctrl.int_active   = 1'b1;
          if (INT_CYCLES == 1) begin
            ctrl.int_ack = 1'b1;
          end else begin
            state_d = INT_SEQ;
            cnt_d   = CW'(INT_CYCLES - 1);
          end
        end
      end
      LOAD_STALL: begin
        if (ex_branch_taken) begin
          ctrl.flush_decode = 1'b1;
          ctrl.bubble_exe   = 1'b1;
          state_d           = IDLE;
          cnt_d             = '0;
        end else begin
          ctrl.stall_fetch  = 1'b1;
          ctrl.stall_decode = 1'b1;
          ctrl.bubble_exe   = 1'b1;
          cnt_d             = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      INT_SEQ: begin
        // EXE only carries bubbles here, so branch and hazard are ignored.
        ctrl.stall_fetch  = 1'b1;
        ctrl.flush_decode = 1'b1;
        ctrl.int_active   = 1'b1;
        cnt_d             = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          ctrl.int_ack = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (ctrl.stall_fetch && !(&stall_count_q)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Outputs are combinational, so they are forced low for the whole reset.
  assign ctrl_out     = rst ? '0 : ctrl;
  assign stall_fetch  = ctrl_out.stall_fetch;
  assign stall_decode = ctrl_out.stall_decode;
  assign flush_decode = ctrl_out.flush_decode;
  assign bubble_exe   = ctrl_out.bubble_exe;
  assign int_ack      = ctrl_out.int_ack;
  assign int_active   = ctrl_out.int_active;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two configurations share one stimulus stream and
// are checked every cycle against a remaining-cycles model plus literal checkpoints.
module tb_hazard_stall_ctrl;

  localparam int INT_C = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dec_src, dec_dst, ex_dest;
  logic       dec_src_used, dec_dst_used, ex_wb, ex_mem_read, ex_branch_taken, int_req;

  logic        a_sf, a_sd, a_fd, a_be, a_ack, a_act;
  logic        b_sf, b_sd, b_fd, b_be, b_ack, b_act;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_AW(3), .LOAD_LAT(1), .INT_CYCLES(INT_C), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .dec_src(dec_src), .dec_src_used(dec_src_used),
    .dec_dst(dec_dst), .dec_dst_used(dec_dst_used), .ex_dest(ex_dest), .ex_wb(ex_wb),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .int_req(int_req),
    .stall_fetch(a_sf), .stall_decode(a_sd), .flush_decode(a_fd), .bubble_exe(a_be),
    .int_ack(a_ack), .int_active(a_act), .stall_count(a_cnt)
  );

  hazard_stall_ctrl #(.REG_AW(3), .LOAD_LAT(3), .INT_CYCLES(INT_C), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .dec_src(dec_src), .dec_src_used(dec_src_used),
    .dec_dst(dec_dst), .dec_dst_used(dec_dst_used), .ex_dest(ex_dest), .ex_wb(ex_wb),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .int_req(int_req),
    .stall_fetch(b_sf), .stall_decode(b_sd), .flush_decode(b_fd), .bubble_exe(b_be),
    .int_ack(b_ack), .int_active(b_act), .stall_count(b_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int cmax(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  // Model: remaining forced cycles of a load stall / interrupt entry per instance.
  int    ld_left[2];
  int    int_left[2];
  int    scnt[2];
  string fname[6] = '{"stall_fetch", "stall_decode", "flush_decode", "bubble_exe", "int_ack", "int_active"};

  initial begin
    for (int k = 0; k < 2; k++) begin
      ld_left[k] = 0; int_left[k] = 0; scnt[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [5:0] ex;
      logic [5:0] ac;
      bit         hz;
      string      p;
      hz = ex_wb && ex_mem_read &&
           ((dec_src_used && dec_src == ex_dest) || (dec_dst_used && dec_dst == ex_dest));
      ex = '0;
      // field order {stall_fetch, stall_decode, flush_decode, bubble_exe, int_ack, int_active}
      if (rst) begin
        ld_left[k] = 0; int_left[k] = 0; scnt[k] = 0;
      end else if (int_left[k] > 0) begin
        ex = {4'b1010, (int_left[k] == 1), 1'b1};
        int_left[k]--;
      end else if (ld_left[k] > 0) begin
        if (ex_branch_taken) begin
          ex = 6'b001100; ld_left[k] = 0;
        end else begin
          ex = 6'b110100; ld_left[k]--;
        end
      end else if (ex_branch_taken) begin
        ex = 6'b001100;
      end else if (hz) begin
        ex = 6'b110100; ld_left[k] = lat(k) - 1;
      end else if (int_req) begin
        ex = {4'b1010, (INT_C == 1), 1'b1};
        int_left[k] = INT_C - 1;
      end
      ac = (k == 0) ? {a_sf, a_sd, a_fd, a_be, a_ack, a_act} : {b_sf, b_sd, b_fd, b_be, b_ack, b_act};
      p  = (k == 0) ? "a." : "b.";
      for (int i = 0; i < 6; i++) chk({p, fname[i]}, 32'(ac[5-i]), int'(ex[5-i]));
      chk({p, "stall_count"}, (k == 0) ? 32'(a_cnt) : 32'(b_cnt), scnt[k]);
      if (!rst && ex[5] && scnt[k] < cmax(k)) scnt[k]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    dec_src = '0; dec_dst = '0; ex_dest = '0;
    dec_src_used = 0; dec_dst_used = 0; ex_wb = 0; ex_mem_read = 0;
    ex_branch_taken = 0; int_req = 0;
  endtask

  task automatic load_use();
    ex_wb = 1; ex_mem_read = 1; ex_dest = 3'd3; dec_src = 3'd3; dec_src_used = 1;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    tick(); tick();
    @(negedge clk);
    chk("rst.a_cnt", 32'(a_cnt), 0);
    chk("rst.b_sf", 32'(b_sf), 0);
    tick(); rst = 1'b0;
    tick();

    // load-use on src
    load_use();
    @(negedge clk);
    chk("lu.a_sf", 32'(a_sf), 1); chk("lu.b_sd", 32'(b_sd), 1); chk("lu.a_be", 32'(a_be), 1);
    tick(); idle_in();
    @(negedge clk); chk("lu2.b_sf", 32'(b_sf), 1); chk("lu2.a_sf", 32'(a_sf), 0);
    tick();
    @(negedge clk); chk("lu3.b_sf", 32'(b_sf), 1);
    tick();
    @(negedge clk);
    chk("lu4.b_sf", 32'(b_sf), 0); chk("lu.a_cnt", 32'(a_cnt), 1); chk("lu.b_cnt", 32'(b_cnt), 3);

    // no hazard variants, then a dst-operand hazard
    tick(); load_use(); ex_mem_read = 0;
    @(negedge clk); chk("nh.a_sf", 32'(a_sf), 0); chk("nh.b_be", 32'(b_be), 0);
    tick(); ex_mem_read = 1; dec_src_used = 0; dec_dst = 3'd5; dec_dst_used = 1;
    @(negedge clk); chk("nh2.b_sf", 32'(b_sf), 0);
    tick(); dec_dst = 3'd3;
    @(negedge clk); chk("dst.a_sf", 32'(a_sf), 1);
    tick(); idle_in(); tick(); tick(); tick();

    // branch vs hazard
    load_use(); ex_branch_taken = 1;
    @(negedge clk);
    chk("br.a_fd", 32'(a_fd), 1); chk("br.b_be", 32'(b_be), 1);
    chk("br.b_sf", 32'(b_sf), 0); chk("br.a_sd", 32'(a_sd), 0);
    tick(); ex_branch_taken = 0;
    @(negedge clk); chk("brh.b_sf", 32'(b_sf), 1);
    tick(); idle_in(); ex_branch_taken = 1;
    @(negedge clk); chk("brls.b_fd", 32'(b_fd), 1); chk("brls.b_sf", 32'(b_sf), 0);
    tick(); idle_in();
    @(negedge clk); chk("brls2.b_sf", 32'(b_sf), 0);

    // interrupt entry, then int_req held past int_ack
    tick(); int_req = 1;
    @(negedge clk);
    chk("int1.a_act", 32'(a_act), 1); chk("int1.a_ack", 32'(a_ack), 0);
    chk("int1.b_sf", 32'(b_sf), 1); chk("int1.a_fd", 32'(a_fd), 1);
    tick();
    @(negedge clk); chk("int2.a_act", 32'(a_act), 1); chk("int2.b_ack", 32'(b_ack), 1);
    tick();
    @(negedge clk); chk("int3.a_act", 32'(a_act), 1); chk("int3.a_ack", 32'(a_ack), 0);
    tick();
    @(negedge clk); chk("int4.b_ack", 32'(b_ack), 1);
    tick(); int_req = 0;
    @(negedge clk);
    chk("int5.a_act", 32'(a_act), 0); chk("sum.a_cnt", 32'(a_cnt), 7); chk("sum.b_cnt", 32'(b_cnt), 11);

    // reset in the first INT_SEQ cycle
    tick(); int_req = 1;
    @(negedge clk); chk("ri.a_act", 32'(a_act), 1);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("ri.a_act0", 32'(a_act), 0); chk("ri.a_ack", 32'(a_ack), 0); chk("ri.b_ack", 32'(b_ack), 0);
    chk("ri.b_sf", 32'(b_sf), 0); chk("ri.a_cnt", 32'(a_cnt), 0); chk("ri.b_cnt", 32'(b_cnt), 0);
    tick(); rst = 1'b0; int_req = 0;
    tick();

    // 20 stall cycles: 4-bit counter saturates
    load_use();
    repeat (20) tick();
    idle_in();
    @(negedge clk); chk("sat.b_cnt", 32'(b_cnt), 15); chk("sat.a_cnt", 32'(a_cnt), 20);

    // randomized traffic
    repeat (1500) begin
      tick();
      rst             = ($urandom_range(0, 99) == 0);
      dec_src         = 3'($urandom_range(0, 7));
      dec_dst         = 3'($urandom_range(0, 7));
      ex_dest         = 3'($urandom_range(0, 7));
      dec_src_used    = ($urandom_range(0, 3) != 0);
      dec_dst_used    = ($urandom_range(0, 1) != 0);
      ex_wb           = ($urandom_range(0, 3) != 0);
      ex_mem_read     = ($urandom_range(0, 1) != 0);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      int_req         = ($urandom_range(0, 5) == 0);
    end
    tick(); rst = 1'b0; idle_in();
    tick(); tick();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
